instr_exec_reader: RTL and testbench

- Read-side consumer of the instruction register stack. On `start`, it walks a range of stack locations by driving `read_pointer` and captures each `instruction_word`.
- For each captured word it executes the opcode on the operands. It then presents the result to a downstream checker or scoreboard on a valid/ready handshake.
- It is the hardware counterpart of the test's write sequence, so it needs no visual inspection of read-back values.

---
 rtl/instr_exec_reader_if.sv | 37 +++
 rtl/instr_exec_reader.sv | 242 ++++++++++++++++++++++++
 tb/tb_instr_exec_reader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_exec_reader_if.sv
// -----------------------------------------------------------------------------
// instr_exec_reader_if
// Result channel between instr_exec_reader and its downstream checker.
// One result per valid/ready handshake.
//
// Signals:
//   res_valid   producer -> consumer   result available
//   res_ready   consumer -> producer   consumer accepts the result
//   res_addr    producer -> consumer   stack location the result came from
//   res_opcode  producer -> consumer   executed opcode
//   res_value   producer -> consumer   signed 2*OP_W result
//   res_err     producer -> consumer   divide/modulo by zero or illegal opcode
//
// Modports: master (instr_exec_reader side), slave (consumer side).
// -----------------------------------------------------------------------------
interface instr_exec_reader_if #(
  parameter int OP_W   = 32,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 4
);
  logic                     res_valid;
  logic                     res_ready;
  logic [ADDR_W-1:0]        res_addr;
  logic [OPC_W-1:0]         res_opcode;
  logic signed [2*OP_W-1:0] res_value;
  logic                     res_err;

  modport master (
    output res_valid, res_addr, res_opcode, res_value, res_err,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_addr, res_opcode, res_value, res_err,
    output res_ready
  );
endinterface

// File: rtl/instr_exec_reader.sv
// -----------------------------------------------------------------------------
// instr_exec_reader
// Walks a range of instruction-stack locations, executes each
// {opc, op_a, op_b} word and presents the result on a valid/ready channel.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             begin a walk (sampled only while idle)
//   first_addr        first stack location to read
//   count             number of locations to read, 0..2**ADDR_W
//   read_pointer      registered stack address
//   instruction_word  {opc, op_a, op_b} returned for read_pointer
//   busy              high whenever a walk is in progress
//   done              one-cycle pulse after a walk completes
//   acc_sum           running sum of error-free results (optional)
//   res_if            result channel (master modport)
//
// Optional feature: define INSTR_EXEC_ACCUM_EN to add the acc_sum output.
// -----------------------------------------------------------------------------
module instr_exec_reader #(
  parameter int OP_W   = 32,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        first_addr,
  input  logic [ADDR_W:0]          count,
  output logic [ADDR_W-1:0]        read_pointer,
  input  logic [OPC_W+2*OP_W-1:0]  instruction_word,
  output logic                     busy,
  output logic                     done,
`ifdef INSTR_EXEC_ACCUM_EN
  output logic [2*OP_W-1:0]        acc_sum,
`endif
  instr_exec_reader_if.master      res_if
);

  localparam int WORD_W = OPC_W + 2*OP_W;
  localparam int RES_W  = 2*OP_W;

  localparam logic [OPC_W-1:0] OPC_ZERO  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_PASSA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_PASSB = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_MULT  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_MOD   = OPC_W'(7);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Executes one instruction word; returns {err, value}. Operands are
  // sign-extended first so the product and the -2^(OP_W-1)/-1 quotient are
  // exact. SV '/' truncates toward zero and '%' follows the dividend's sign.
  function automatic logic [RES_W:0] exec_op(input logic [WORD_W-1:0] w);
    logic [OPC_W-1:0]        opc;
    logic signed [RES_W-1:0] a;
    logic signed [RES_W-1:0] b;
    logic signed [RES_W-1:0] r;
    logic                    err;
    opc = w[WORD_W-1 -: OPC_W];
    a   = {{OP_W{w[2*OP_W-1]}}, w[2*OP_W-1:OP_W]};
    b   = {{OP_W{w[OP_W-1]}}, w[OP_W-1:0]};
    r   = '0;
    err = 1'b0;
    case (opc)
      OPC_ZERO:  r = '0;
      OPC_PASSA: r = a;
      OPC_PASSB: r = b;
      OPC_ADD:   r = a + b;
      OPC_SUB:   r = a - b;
      OPC_MULT:  r = a * b;
      OPC_DIV: begin
        if (b == '0) begin
          err = 1'b1;
          r   = '0;
        end else begin
          r = a / b;
        end
      end
      OPC_MOD: begin
        if (b == '0) begin
          err = 1'b1;
          r   = '0;
        end else begin
          r = a % b;
        end
      end
      default: begin
        err = 1'b1;
        r   = '0;
      end
    endcase
    return {err, r};
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       rp_q, rp_d;
  logic [ADDR_W:0]         rem_q, rem_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic                    rv_q, rv_d;
  logic [ADDR_W-1:0]       ra_q, ra_d;
  logic [OPC_W-1:0]        ro_q, ro_d;
  logic signed [RES_W-1:0] rval_q, rval_d;
  logic                    rerr_q, rerr_d;
  logic                    busy_q, done_q;
  logic [RES_W:0]          exec_s;
  logic                    accept_s;
`ifdef INSTR_EXEC_ACCUM_EN
  logic [RES_W-1:0]        acc_q, acc_d;
`endif

  assign exec_s   = exec_op(word_q);
  assign accept_s = rv_q & res_if.res_ready;

  // Next-state and datapath control for the walk.
  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    rem_d   = rem_q;
    word_d  = word_q;
    rv_d    = rv_q;
    ra_d    = ra_q;
    ro_d    = ro_q;
    rval_d  = rval_q;
    rerr_d  = rerr_q;
`ifdef INSTR_EXEC_ACCUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef INSTR_EXEC_ACCUM_EN
          acc_d = '0;
`endif
          if (count != '0) begin
            rp_d    = first_addr;
            rem_d   = count;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        word_d  = instruction_word;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        rerr_d  = exec_s[RES_W];
        rval_d  = exec_s[RES_W-1:0];
        ro_d    = word_q[WORD_W-1 -: OPC_W];
        ra_d    = rp_q;
        rv_d    = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (accept_s) begin
          rv_d  = 1'b0;
          rem_d = rem_q - (ADDR_W+1)'(1);
`ifdef INSTR_EXEC_ACCUM_EN
          if (!rerr_q) begin
            acc_d = acc_q + rval_q;
          end else begin
            acc_d = acc_q;
          end
`endif
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = S_DONE;
          end else begin
            // Natural ADDR_W-bit wrap takes the last location back to 0.
            rp_d    = rp_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; done trails the DONE state by one cycle so
  // the pulse coincides with busy falling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rp_q    <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      rv_q    <= 1'b0;
      ra_q    <= '0;
      ro_q    <= '0;
      rval_q  <= '0;
      rerr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef INSTR_EXEC_ACCUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      rv_q    <= rv_d;
      ra_q    <= ra_d;
      ro_q    <= ro_d;
      rval_q  <= rval_d;
      rerr_q  <= rerr_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_DONE);
`ifdef INSTR_EXEC_ACCUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign read_pointer      = rp_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign res_if.res_valid  = rv_q;
  assign res_if.res_addr   = ra_q;
  assign res_if.res_opcode = ro_q;
  assign res_if.res_value  = rval_q;
  assign res_if.res_err    = rerr_q;
`ifdef INSTR_EXEC_ACCUM_EN
  assign acc_sum           = acc_q;
`endif

endmodule

// File: tb/tb_instr_exec_reader.sv
// -----------------------------------------------------------------------------
// tb_instr_exec_reader
// Directed bench for instr_exec_reader. A behavioural 32-entry stack answers
// read_pointer combinationally; expected results are hand-computed constants.
// Builds with or without INSTR_EXEC_ACCUM_EN.
// -----------------------------------------------------------------------------
module tb_instr_exec_reader;
  localparam int OP_W   = 32;
  localparam int ADDR_W = 5;
  localparam int OPC_W  = 4;

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_addr;
  logic [5:0]  count;
  logic [4:0]  read_pointer;
  logic [67:0] instruction_word;
  logic        busy;
  logic        done;
`ifdef INSTR_EXEC_ACCUM_EN
  logic [63:0] acc_sum;
`endif
  logic [67:0] mem [32];

  int tests_run    = 0;
  int tests_failed = 0;

  instr_exec_reader_if #(.OP_W(OP_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus ();

  instr_exec_reader #(.OP_W(OP_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .busy             (busy),
    .done             (done),
`ifdef INSTR_EXEC_ACCUM_EN
    .acc_sum          (acc_sum),
`endif
    .res_if           (bus.master)
  );

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  function automatic logic [67:0] mk(input logic [3:0] o, input int a, input int b);
    return {o, 32'(a), 32'(b)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for res_valid; seen reports whether it arrived.
  task automatic wait_valid(output bit seen);
    seen = bus.res_valid;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick;
      seen = bus.res_valid;
    end
  endtask

  // Bounded wait for the done pulse.
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick;
      seen = done;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; first_addr = 5'd0; count = 6'd0;
    bus.res_ready = 1'b0;
    tick; tick;
    tests_run++;
    if (read_pointer !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rp=%0d busy=%b done=%b expected 0 0 0", read_pointer, busy, done);
    end
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.res_err !== 1'b0 || bus.res_value !== 64'd0 ||
        bus.res_addr !== 5'd0 || bus.res_opcode !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_res: valid=%b err=%b val=%0d addr=%0d opc=%0d expected all 0",
               bus.res_valid, bus.res_err, bus.res_value, bus.res_addr, bus.res_opcode);
    end
`ifdef INSTR_EXEC_ACCUM_EN
    tests_run++;
    if (acc_sum !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_acc: got %0d expected 0", acc_sum);
    end
`endif
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    mem[3] = mk(OP_ADD, 7, 5);
    bus.res_ready = 1'b1; first_addr = 5'd3; count = 6'd1; start = 1'b1;
    tick;                       // start sampled at edge N
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || read_pointer !== 5'd3) begin
      tests_failed++;
      $display("FAIL single_read: busy=%b rp=%0d expected 1 3", busy, read_pointer);
    end
    tick;                       // N+1
    tests_run++;
    if (bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early_valid: got %b expected 0", bus.res_valid);
    end
    tick;                       // N+2
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_addr !== 5'd3 || bus.res_value !== 64'sd12 ||
        bus.res_err !== 1'b0 || bus.res_opcode !== OP_ADD) begin
      tests_failed++;
      $display("FAIL single_result: valid=%b addr=%0d val=%0d err=%b opc=%0d expected 1 3 12 0 3",
               bus.res_valid, bus.res_addr, $signed(bus.res_value), bus.res_err, bus.res_opcode);
    end
    tick;                       // accept edge
    tests_run++;
    if (bus.res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_accept: valid=%b done=%b busy=%b expected 0 0 1", bus.res_valid, done, busy);
    end
    tick;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: done=%b busy=%b expected 1 0", done, busy);
    end
    tick;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done_width: done=%b expected 0", done);
    end
`ifdef INSTR_EXEC_ACCUM_EN
    tests_run++;
    if (acc_sum !== 64'd12) begin
      tests_failed++;
      $display("FAIL single_acc: got %0d expected 12", $signed(acc_sum));
    end
`endif
  endtask

  task automatic test_wrap;
    logic [4:0]         exp_addr [3];
    logic signed [63:0] exp_val  [3];
    bit seen;
    mem[30] = mk(OP_SUB, -4, 6);
    mem[31] = mk(OP_MULT, -3, 15);
    mem[0]  = mk(OP_MOD, -7, 2);
    exp_addr[0] = 5'd30; exp_val[0] = -64'sd10;
    exp_addr[1] = 5'd31; exp_val[1] = -64'sd45;
    exp_addr[2] = 5'd0;  exp_val[2] = -64'sd1;
    bus.res_ready = 1'b1; first_addr = 5'd30; count = 6'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(seen);
      tests_run++;
      if (!seen || bus.res_addr !== exp_addr[i] || read_pointer !== exp_addr[i] ||
          bus.res_value !== exp_val[i] || bus.res_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL wrap_result%0d: seen=%b addr=%0d rp=%0d val=%0d err=%b expected addr %0d val %0d",
                 i, seen, bus.res_addr, read_pointer, $signed(bus.res_value), bus.res_err,
                 exp_addr[i], exp_val[i]);
      end
      tick;                     // accept
    end
    wait_done(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL wrap_done: done pulse not seen, expected 1");
    end
`ifdef INSTR_EXEC_ACCUM_EN
    tests_run++;
    if (acc_sum !== 64'hFFFF_FFFF_FFFF_FFC8) begin
      tests_failed++;
      $display("FAIL wrap_acc: got %0d expected -56", $signed(acc_sum));
    end
`endif
    tick;
  endtask

  task automatic test_errors;
    bit seen;
    mem[5] = mk(OP_DIV, 9, 0);
    mem[6] = mk(4'd9, 1, 2);
    bus.res_ready = 1'b1; first_addr = 5'd5; count = 6'd2; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_valid(seen);
      tests_run++;
      if (!seen || bus.res_value !== 64'd0 || bus.res_err !== 1'b1) begin
        tests_failed++;
        $display("FAIL err_result%0d: seen=%b val=%0d err=%b expected val 0 err 1",
                 i, seen, $signed(bus.res_value), bus.res_err);
      end
      tick;
    end
    wait_done(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL err_done: done pulse not seen, expected 1");
    end
`ifdef INSTR_EXEC_ACCUM_EN
    tests_run++;
    if (acc_sum !== 64'd0) begin
      tests_failed++;
      $display("FAIL err_acc: got %0d expected 0", $signed(acc_sum));
    end
`endif
    tick;
  endtask

  task automatic test_backpressure;
    bit seen;
    int bad;
    mem[10] = mk(OP_PASSA, 123, -1);
    mem[11] = mk(OP_PASSB, 5, -77);
    bus.res_ready = 1'b0; first_addr = 5'd10; count = 6'd2; start = 1'b1;
    tick;
    start = 1'b0;
    wait_valid(seen);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!seen || bus.res_valid !== 1'b1 || bus.res_value !== 64'sd123 ||
          bus.res_addr !== 5'd10 || read_pointer !== 5'd10 || bus.res_opcode !== OP_PASSA)
        bad++;
      tick;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: %0d unstable cycles expected 0", bad);
    end
    bus.res_ready = 1'b1;
    tick;                       // exactly one accept
    tests_run++;
    if (bus.res_valid !== 1'b0 || read_pointer !== 5'd11) begin
      tests_failed++;
      $display("FAIL bp_accept: valid=%b rp=%0d expected 0 11", bus.res_valid, read_pointer);
    end
    wait_valid(seen);
    tests_run++;
    if (!seen || bus.res_addr !== 5'd11 || bus.res_value !== -64'sd77) begin
      tests_failed++;
      $display("FAIL bp_second: seen=%b addr=%0d val=%0d expected addr 11 val -77",
               seen, bus.res_addr, $signed(bus.res_value));
    end
    wait_done(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL bp_done: done pulse not seen, expected 1");
    end
    tick;
  endtask

  task automatic test_count_zero;
    bus.res_ready = 1'b1; first_addr = 5'd7; count = 6'd0; start = 1'b1;
    tick;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_busy: busy=%b done=%b valid=%b expected 1 0 0", busy, done, bus.res_valid);
    end
    tick;
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done: done=%b busy=%b valid=%b expected 1 0 0", done, busy, bus.res_valid);
    end
    tick;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_width: done=%b expected 0", done);
    end
  endtask

  task automatic test_back_to_back;
    int nres;
    logic [4:0] last_addr;
    logic signed [63:0] first_val;
    bit seen;
    mem[12] = mk(OP_DIV, -7, 2);
    mem[13] = mk(OP_ZERO, 5, 5);
    bus.res_ready = 1'b1; first_addr = 5'd12; count = 6'd2; start = 1'b1;
    nres = 0; last_addr = 5'd0; first_val = 64'sd0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick;
      // a stray start mid-walk must be ignored
      if (c == 2) begin
        start = 1'b1; first_addr = 5'd20; count = 6'd5;
      end else begin
        start = 1'b0;
      end
      if (bus.res_valid) begin
        if (nres == 0) first_val = bus.res_value;
        nres++;
        last_addr = bus.res_addr;
      end
      seen = done;
    end
    start = 1'b0;
    tests_run++;
    if (!seen || nres != 2 || last_addr !== 5'd13 || first_val !== -64'sd3) begin
      tests_failed++;
      $display("FAIL b2b_walk: done=%b results=%0d last_addr=%0d first_val=%0d expected 1 2 13 -3",
               seen, nres, last_addr, first_val);
    end
    tick; tick;
    tests_run++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: busy=%b valid=%b expected 0 0", busy, bus.res_valid);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    bit done_seen;
    mem[16] = mk(OP_PASSA, 100, 0);
    mem[0]  = mk(OP_ADD, 1, 1);
    bus.res_ready = 1'b0; first_addr = 5'd16; count = 6'd4; start = 1'b1;
    tick;
    start = 1'b0;
    wait_valid(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL rst_mid_valid: res_valid not seen, expected 1");
    end
    reset = 1'b1;
    tick;
    tests_run++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0 || read_pointer !== 5'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_state: valid=%b busy=%b rp=%0d expected 0 0 0", bus.res_valid, busy, read_pointer);
    end
    reset = 1'b0;
    done_seen = done;
    for (int c = 0; c < 4; c++) begin
      tick;
      done_seen = done_seen | done;
    end
    tests_run++;
    if (done_seen) begin
      tests_failed++;
      $display("FAIL rst_mid_nodone: done pulse seen=%b expected 0", done_seen);
    end
    bus.res_ready = 1'b1; first_addr = 5'd0; count = 6'd1; start = 1'b1;
    tick;
    start = 1'b0;
    wait_valid(seen);
    tests_run++;
    if (!seen || bus.res_addr !== 5'd0 || bus.res_value !== 64'sd2) begin
      tests_failed++;
      $display("FAIL rst_mid_restart: seen=%b addr=%0d val=%0d expected addr 0 val 2",
               seen, bus.res_addr, $signed(bus.res_value));
    end
    wait_done(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL rst_mid_done: done pulse not seen, expected 1");
    end
    tick;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 68'd0;
    test_reset;
    test_single;
    test_wrap;
    test_errors;
    test_backpressure;
    test_count_zero;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
